// File: rtl/keypad_scanner_if.sv
// keypad_scanner_if -- signal bundle between the keypad scanner and its user.
//   row_in      : 4-bit keypad rows (asynchronous, pulled up, 0 = closed)
//   clr         : synchronous clear of the entry buffer
//   col_out     : 4-bit active-low one-cold column strobe
//   key_code    : code of the last accepted key
//   key_strobe  : one-cycle pulse on key acceptance
//   input_data  : 32-bit hex entry buffer, nibble 0 newest
//   input_valid : per-nibble valid bits
// slave modport = scanner side, master modport = consumer/keypad side.
interface keypad_scanner_if;
  logic [3:0]  row_in;
  logic        clr;
  logic [3:0]  col_out;
  logic [3:0]  key_code;
  logic        key_strobe;
  logic [31:0] input_data;
  logic [7:0]  input_valid;

  modport master (
    output row_in, clr,
    input  col_out, key_code, key_strobe, input_data, input_valid
  );

  modport slave (
    input  row_in, clr,
    output col_out, key_code, key_strobe, input_data, input_valid
  );
endinterface

// File: rtl/keypad_scanner.sv
// keypad_scanner -- 4x4 matrix keypad scanner with debounce and hex entry buffer.
// Ports:
//   clk : system clock, rising edge
//   rst : synchronous active-high reset
//   bus : keypad_scanner_if.slave (row_in, clr in; col_out, key_code,
//         key_strobe, input_data, input_valid out)
// Parameters:
//   SCAN_DIV  : scan tick every SCAN_DIV+1 clocks
//   DEB_TICKS : consecutive scan ticks needed to accept a press or release
// Build option:
//   KEYPAD_BACKSPACE_EN : when defined, key 4'hF removes the newest digit
//                         instead of being entered.
module keypad_scanner #(
  parameter int unsigned SCAN_DIV  = 249999,
  parameter int unsigned DEB_TICKS = 4
) (
  input logic             clk,
  input logic             rst,
  keypad_scanner_if.slave bus
);

  localparam int unsigned DIV_W = (SCAN_DIV < 1) ? 1 : $clog2(SCAN_DIV + 1);
  localparam int unsigned DEB_W = (DEB_TICKS < 1) ? 1 : $clog2(DEB_TICKS + 1);

  typedef enum logic [1:0] {SCAN, PRESS_DEB, HELD, REL_DEB} state_e;

  state_e             state_q, state_d;
  logic [3:0]         sync1_q, sync2_q;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [DEB_W-1:0]   deb_q, deb_d;
  logic [1:0]         col_q, col_d;
  logic [1:0]         row_q, row_d;
  logic [3:0]         code_q, code_d;
  logic               strobe_q, strobe_d;
  logic [31:0]        data_q, data_d;
  logic [7:0]         valid_q, valid_d;

  logic               tick;
  logic               row_low;
  logic               accept;
  logic [1:0]         low_row;
  logic [3:0]         new_code;

  assign tick     = (div_q == DIV_W'(SCAN_DIV));
  assign row_low  = ~sync2_q[row_q];
  assign accept   = (state_q == PRESS_DEB) && (deb_q == DEB_W'(DEB_TICKS));
  assign new_code = {row_q, col_q};

  // Lowest-index closed row wins when several are low at the detecting tick.
  always_comb begin
    low_row = 2'd3;
    if (!sync2_q[0])      low_row = 2'd0;
    else if (!sync2_q[1]) low_row = 2'd1;
    else if (!sync2_q[2]) low_row = 2'd2;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= SCAN;
      sync1_q  <= 4'hF;
      sync2_q  <= 4'hF;
      div_q    <= '0;
      deb_q    <= '0;
      col_q    <= '0;
      row_q    <= '0;
      code_q   <= '0;
      strobe_q <= 1'b0;
      data_q   <= '0;
      valid_q  <= '0;
    end else begin
      state_q  <= state_d;
      sync1_q  <= bus.row_in;
      sync2_q  <= sync1_q;
      div_q    <= div_d;
      deb_q    <= deb_d;
      col_q    <= col_d;
      row_q    <= row_d;
      code_q   <= code_d;
      strobe_q <= strobe_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    div_d    = tick ? '0 : div_q + DIV_W'(1);
    deb_d    = deb_q;
    col_d    = col_q;
    row_d    = row_q;
    code_d   = code_q;
    strobe_d = 1'b0;
    data_d   = data_q;
    valid_d  = valid_q;

    case (state_q)
      SCAN: begin
        if (tick) begin
          if (&sync2_q) begin
            col_d = col_q + 2'd1;
          end else begin
            row_d   = low_row;
            deb_d   = DEB_W'(1);
            state_d = PRESS_DEB;
          end
        end
      end
      PRESS_DEB: begin
        // Acceptance fires the cycle after the count reaches DEB_TICKS.
        if (accept) begin
          code_d   = new_code;
          strobe_d = 1'b1;
          state_d  = HELD;
        end else if (tick) begin
          if (row_low) deb_d = deb_q + DEB_W'(1);
          else         state_d = SCAN;
        end
      end
      HELD: begin
        if (tick && !row_low) begin
          deb_d   = DEB_W'(1);
          state_d = REL_DEB;
        end
      end
      REL_DEB: begin
        if (deb_q == DEB_W'(DEB_TICKS)) begin
          state_d = SCAN;
        end else if (tick) begin
          if (!row_low) deb_d = deb_q + DEB_W'(1);
          else          state_d = HELD;
        end
      end
      default: state_d = SCAN;
    endcase

    // clr outranks a same-cycle acceptance: the digit is dropped.
    if (bus.clr) begin
      data_d  = '0;
      valid_d = '0;
    end else if (accept) begin
`ifdef KEYPAD_BACKSPACE_EN
      if (new_code == 4'hF) begin
        data_d  = {4'h0, data_q[31:4]};
        valid_d = {1'b0, valid_q[7:1]};
      end else
`endif
      begin
        data_d  = {data_q[27:0], new_code};
        valid_d = {valid_q[6:0], 1'b1};
      end
    end
  end

  // Output logic
  always_comb begin
    bus.col_out     = ~(4'b0001 << col_q);
    bus.key_code    = code_q;
    bus.key_strobe  = strobe_q;
    bus.input_data  = data_q;
    bus.input_valid = valid_q;
  end

endmodule

// File: tb/tb_keypad_scanner.sv
module tb_keypad_scanner;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  keypad_scanner_if bus ();

  keypad_scanner #(.SCAN_DIV(3), .DEB_TICKS(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Physical keypad: a closed key pulls its row low only while its column is strobed.
  logic       key_down;
  logic [3:0] key_sel;
  logic       bounce;
  assign bus.row_in = bounce ? 4'hB :
                      (key_down && !bus.col_out[key_sel[1:0]]) ? ~(4'b0001 << key_sel[3:2]) :
                      4'hF;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0]  code;
    logic [31:0] data;
    logic [7:0]  valid;
  } exp_t;
  exp_t sbq[$];

  // Reference: list of entered digits, oldest first, at most eight.
  logic [3:0] digits[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model_data();
    logic [31:0] d = 0;
    foreach (digits[i]) d = d * 16 + 32'(digits[i]);
    return d;
  endfunction

  function automatic logic [7:0] model_valid();
    return 8'((1 << digits.size()) - 1);
  endfunction

  task automatic model_key(input logic [3:0] k);
`ifdef KEYPAD_BACKSPACE_EN
    if (k == 4'hF) begin
      if (digits.size() > 0) void'(digits.pop_back());
      return;
    end
`endif
    digits.push_back(k);
    if (digits.size() > 8) void'(digits.pop_front());
  endtask

  task automatic expect_strobe(input logic [3:0] k);
    exp_t e;
    e.code  = k;
    e.data  = model_data();
    e.valid = model_valid();
    sbq.push_back(e);
  endtask

  task automatic press(input logic [3:0] k, input int hold, input int gap, input bit with_clr);
    if (with_clr) digits.delete();
    else          model_key(k);
    expect_strobe(k);
    @(negedge clk);
    key_sel  = k;
    key_down = 1'b1;
    bus.clr  = with_clr;
    repeat (hold) @(negedge clk);
    key_down = 1'b0;
    bus.clr  = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic clr_pulse();
    @(negedge clk);
    bus.clr = 1'b1;
    @(negedge clk);
    bus.clr = 1'b0;
    digits.delete();
  endtask

  // Monitor: every strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && bus.key_strobe) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe actual key_code=%h required no strobe", bus.key_code);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check("strobe_key_code", 32'(bus.key_code), 32'(e.code));
        check("strobe_input_data", bus.input_data, e.data);
        check("strobe_input_valid", 32'(bus.input_valid), 32'(e.valid));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] exp_col;
    logic [3:0] c0;
    rst      = 1'b1;
    bus.clr  = 1'b0;
    key_down = 1'b0;
    key_sel  = '0;
    bounce   = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state
    check("reset_col_out", 32'(bus.col_out), 32'hE);
    check("reset_key_code", 32'(bus.key_code), 32'h0);
    check("reset_key_strobe", 32'(bus.key_strobe), 32'h0);
    check("reset_input_data", bus.input_data, 32'h0);
    check("reset_input_valid", 32'(bus.input_valid), 32'h0);

    // Idle rotation: one column step every SCAN_DIV+1 = 4 cycles
    for (int k = 0; k < 20; k++) begin
      exp_col = ~(4'b0001 << ((k / 4) % 4));
      check("idle_col_out", 32'(bus.col_out), 32'(exp_col));
      @(negedge clk);
    end

    // Row 2 on column 1
    press(4'h9, 60, 30, 1'b0);
    check("key9_code", 32'(bus.key_code), 32'h9);
    check("key9_data", bus.input_data, 32'h9);
    check("key9_valid", 32'(bus.input_valid), 32'h01);

    // Bounce: raw row low for 4 cycles, seen by exactly one tick
    bounce = 1'b1;
    repeat (4) @(negedge clk);
    bounce = 1'b0;
    repeat (16) @(negedge clk);
    c0 = bus.col_out;
    repeat (4) @(negedge clk);
    check("bounce_rotation", 32'(bus.col_out), 32'({c0[2:0], c0[3]}));
    check("bounce_data", bus.input_data, 32'h9);

    // Idle clear
    clr_pulse();
    check("clr_data", bus.input_data, 32'h0);
    check("clr_valid", 32'(bus.input_valid), 32'h0);

    // Nine digits: oldest discarded, valid saturates
    for (int k = 1; k <= 9; k++) press(4'(k), 50, 26, 1'b0);
    check("nine_data", bus.input_data, 32'h23456789);
    check("nine_valid", 32'(bus.input_valid), 32'hFF);

    // clr held across the strobe of key 5: digit dropped, code still updates
    press(4'h5, 50, 26, 1'b1);
    check("clr_strobe_data", bus.input_data, 32'h0);
    check("clr_strobe_valid", 32'(bus.input_valid), 32'h0);
    check("clr_strobe_code", 32'(bus.key_code), 32'h5);

    // A, B, then F
    press(4'hA, 50, 26, 1'b0);
    press(4'hB, 50, 26, 1'b0);
    press(4'hF, 50, 26, 1'b0);
`ifdef KEYPAD_BACKSPACE_EN
    check("bs_data", bus.input_data, 32'hA);
    check("bs_valid", 32'(bus.input_valid), 32'h01);
`else
    check("f_data", bus.input_data, 32'hABF);
    check("f_valid", 32'(bus.input_valid), 32'h07);
`endif

    // Reset while held: strobe before, then re-detected from SCAN after reset
    model_key(4'h6);
    expect_strobe(4'h6);
    @(negedge clk);
    key_sel  = 4'h6;
    key_down = 1'b1;
    repeat (50) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("held_reset_data", bus.input_data, 32'h0);
    check("held_reset_strobe", 32'(bus.key_strobe), 32'h0);
    digits.delete();
    model_key(4'h6);
    expect_strobe(4'h6);
    repeat (50) @(negedge clk);
    key_down = 1'b0;
    repeat (30) @(negedge clk);

    // Reset during debounce: too early for any acceptance, one strobe afterwards
    @(negedge clk);
    key_sel  = 4'hC;
    key_down = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    digits.delete();
    model_key(4'hC);
    expect_strobe(4'hC);
    repeat (50) @(negedge clk);
    key_down = 1'b0;
    repeat (30) @(negedge clk);
    check("deb_reset_data", bus.input_data, 32'hC);

    // Random keys with occasional clears
    for (int n = 0; n < 14; n++) begin
      if ($urandom_range(0, 3) == 0) clr_pulse();
      press(4'($urandom_range(0, 15)), int'($urandom_range(40, 70)),
            int'($urandom_range(24, 40)), 1'b0);
    end
    check("random_data", bus.input_data, model_data());
    check("random_valid", 32'(bus.input_valid), 32'(model_valid()));

    repeat (20) @(negedge clk);
    check("pending_strobes", 32'(sbq.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
